// File: rtl/axi_lite_sram_if.sv
// AXI-lite read/write channel bundle between a master and the SRAM responder.
// The responder uses the slave modport, the driving master uses the master modport.
interface axi_lite_sram_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arsize, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arsize, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite responder over a word-organised SRAM window, with independent
// read and write FSMs, programmable wait latency, byte strobes and DECERR.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_WAIT | counting down the read access latency
// R_RESP | rvalid high, rdata/rresp held until rready
// W_IDLE | collecting AW and W in any order
// W_WAIT | counting down the write latency, commit on terminal count
// W_RESP | bvalid high, bresp held until bready
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE        = 32'h0f000000,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1
) (
    input  logic             clk,
    input  logic             rst,
    axi_lite_sram_if.slave   bus
);

    localparam int         IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    logic unused_sizes;
    assign unused_sizes = ^{bus.arsize, bus.awsize};

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [3:0]  rd_cnt;
    logic [31:0] ar_addr_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (bus.arvalid)      r_next = R_WAIT;
            R_WAIT: if (rd_cnt == 4'd0)   r_next = R_RESP;
            R_RESP: if (bus.rready)       r_next = R_IDLE;
            default:                      r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            rd_cnt    <= 4'd0;
            ar_addr_q <= 32'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        ar_addr_q <= bus.araddr;
                        rd_cnt    <= RD_CNT_INIT;
                    end
                end
                R_WAIT: begin
                    if (rd_cnt != 4'd0) begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end else if (in_window(ar_addr_q)) begin
                        rdata_q <= mem[word_idx(ar_addr_q)];
                        rresp_q <= RESP_OKAY;
                    end else begin
                        rdata_q <= 32'd0;
                        rresp_q <= RESP_DECERR;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [3:0]  wr_cnt;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic        aw_rdy, w_rdy, aw_fire, w_fire, commit;

    assign aw_rdy      = (w_state == W_IDLE) && !aw_got;
    assign w_rdy       = (w_state == W_IDLE) && !w_got;
    assign aw_fire     = bus.awvalid && aw_rdy;
    assign w_fire      = bus.wvalid && w_rdy;
    assign commit      = (w_state == W_WAIT) && (wr_cnt == 4'd0);
    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if ((aw_got || aw_fire) && (w_got || w_fire)) w_next = W_WAIT;
            W_WAIT: if (wr_cnt == 4'd0)                           w_next = W_RESP;
            W_RESP: if (bus.bready)                               w_next = W_IDLE;
            default:                                              w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            wr_cnt    <= 4'd0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_addr_q <= bus.awaddr;
                        aw_got    <= 1'b1;
                    end
                    if (w_fire) begin
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        w_got   <= 1'b1;
                    end
                    if (w_next == W_WAIT) wr_cnt <= WR_CNT_INIT;
                end
                W_WAIT: begin
                    if (wr_cnt != 4'd0) wr_cnt <= wr_cnt - 4'd1;
                    else bresp_q <= in_window(aw_addr_q) ? RESP_OKAY : RESP_DECERR;
                end
                W_RESP: begin
                    if (bus.bready) begin
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Commit is gated by w_state, which reset forces to W_IDLE, so an
    // interrupted write never reaches the array.
    always_ff @(posedge clk) begin
        if (commit && in_window(aw_addr_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[word_idx(aw_addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
